// File: rtl/contador_pkg.sv
// Shared definitions for the cascaded counter: operation encodings and default geometry.
package contador_pkg;

    // Operation select applied to the counter on each enabled edge
    typedef enum logic [1:0] {
        MODO_UP   = 2'b00,
        MODO_DN   = 2'b01,
        MODO_BIG  = 2'b10,
        MODO_LOAD = 2'b11
    } modo_e;

    // Default geometry gives the classic 16-bit counter built from four nibbles
    localparam int DEF_SLICE_W    = 4;
    localparam int DEF_NUM_SLICES = 4;
    localparam int DEF_STEP_UP    = 1;
    localparam int DEF_STEP_DN    = 1;
    localparam int DEF_STEP_BIG   = 3;

endpackage

// File: rtl/contador_slice.sv
// One SLICE_W-bit stage of the counter datapath: adds or subtracts its slice of the
// step constant, taking a carry/borrow from the stage below and passing one upward.
module contador_slice
    import contador_pkg::*;
#(
    parameter int SLICE_W = DEF_SLICE_W
) (
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_sub,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_s,
    output logic               o_cout
);

    logic [SLICE_W:0] w_sum;
    logic [SLICE_W:0] w_dif;

    // One extra bit holds the carry (add) or the borrow (subtract); a negative
    // difference always sets that top bit, so it doubles as the borrow-out.
    assign w_sum = {1'b0, i_a} + {1'b0, i_b} + (SLICE_W+1)'(i_cin);
    assign w_dif = {1'b0, i_a} - {1'b0, i_b} - (SLICE_W+1)'(i_cin);

    assign {o_cout, o_s} = i_sub ? w_dif : w_sum;

endmodule

// File: rtl/contador_cascada_param.sv
// Parametrised up/down/load counter made of NUM_SLICES cascaded slices. Owns the
// count and per-slice carry registers; the slices only do the arithmetic.
module contador_cascada_param
    import contador_pkg::*;
#(
    parameter int SLICE_W    = DEF_SLICE_W,
    parameter int NUM_SLICES = DEF_NUM_SLICES,
    parameter int STEP_UP    = DEF_STEP_UP,
    parameter int STEP_DN    = DEF_STEP_DN,
    parameter int STEP_BIG   = DEF_STEP_BIG
) (
    input  logic                          clk,
    input  logic                          reset_L,
    input  logic                          enb,
    input  logic [1:0]                    modo,
    input  logic [SLICE_W*NUM_SLICES-1:0] D,
    output logic [SLICE_W*NUM_SLICES-1:0] Q,
    output logic [NUM_SLICES-1:0]         RCO
);

    localparam int W = SLICE_W * NUM_SLICES;

    // Steps are zero-extended to the full word so large steps spill into upper slices
    localparam logic [W-1:0] L_STEP_UP  = W'(STEP_UP);
    localparam logic [W-1:0] L_STEP_DN  = W'(STEP_DN);
    localparam logic [W-1:0] L_STEP_BIG = W'(STEP_BIG);

    logic [W-1:0]          r_q;
    logic [NUM_SLICES-1:0] r_rco;
    logic [W-1:0]          w_step;
    logic                  w_sub;
    logic [W-1:0]          w_next;
    logic [NUM_SLICES:0]   w_carry;

    assign w_sub      = (modo == MODO_DN) || (modo == MODO_BIG);
    assign w_carry[0] = 1'b0;

    // Pick the full-word step for the current operation; load does not use it
    always_comb begin
        w_step = '0;
        case (modo)
            MODO_UP:  w_step = L_STEP_UP;
            MODO_DN:  w_step = L_STEP_DN;
            MODO_BIG: w_step = L_STEP_BIG;
            default:  w_step = '0;
        endcase
    end

    // Chain the slices so each carry/borrow-out feeds the next slice up
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
        contador_slice #(
            .SLICE_W (SLICE_W)
        ) u_slice (
            .i_a    (r_q[gi*SLICE_W +: SLICE_W]),
            .i_b    (w_step[gi*SLICE_W +: SLICE_W]),
            .i_sub  (w_sub),
            .i_cin  (w_carry[gi]),
            .o_s    (w_next[gi*SLICE_W +: SLICE_W]),
            .o_cout (w_carry[gi+1])
        );
    end

    // Register the count and the carry flags of this update; reset beats everything
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_q   <= '0;
            r_rco <= '0;
        end else if (!enb) begin
            r_rco <= '0;
        end else if (modo == MODO_LOAD) begin
            r_q   <= D;
            r_rco <= '0;
        end else begin
            r_q   <= w_next;
            r_rco <= w_carry[NUM_SLICES:1];
        end
    end

    assign Q   = r_q;
    assign RCO = r_rco;

endmodule
